// File: rtl/spi_cfg_master.sv
// spi_cfg_master: queues register-write commands and sends each as a 16-bit
// SPI mode-0 frame {1'b1, addr[6:0], data[7:0]}, MSB first.
module spi_cfg_master #(
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [7:0]    PH_LAST = 8'(CLK_DIV - 1);

    // state | meaning
    // IDLE  | ncs high, waiting for a queued command
    // SETUP | ncs low, bit 15 presented before the first rising edge
    // HIGH  | sclk high, copi stable
    // LOW   | sclk low, copi moved to the next bit
    // GAP   | ncs high guard time after the frame
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    logic [14:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [7:0]    phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shift_q, shift_d;
    logic          sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          push, pop, phase_last;

    assign cmd_ready  = (count_q != FULL);
    assign push       = cmd_valid && cmd_ready;
    assign phase_last = (phase_q == PH_LAST);

    assign sclk = sclk_q;
    assign copi = copi_q;
    assign ncs  = ncs_q;
    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = {1'b1, mem_q[rd_ptr_q]};
                    state_d = SETUP;
                    phase_d = '0;
                    bit_d   = '0;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    copi_d  = 1'b1;
                end
            end
            SETUP: begin
                if (phase_last) begin
                    state_d = HIGH;
                    phase_d = '0;
                    sclk_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_d = LOW;
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    // After the last bit copi simply keeps bit 0
                    if (bit_q != 4'd15) begin
                        copi_d  = shift_q[14];
                        shift_d = shift_q << 1;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            LOW: begin
                if (phase_last) begin
                    phase_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = GAP;
                        ncs_d   = 1'b1;
                        done_d  = 1'b1;
                        bit_d   = '0;
                    end else begin
                        state_d = HIGH;
                        sclk_d  = 1'b1;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            GAP: begin
                if (phase_last) begin
                    state_d = IDLE;
                    phase_d = '0;
                    copi_d  = 1'b0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sclk_q   <= 1'b0;
            copi_q   <= 1'b0;
            ncs_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sclk_q   <= sclk_d;
            copi_q   <= copi_d;
            ncs_q    <= ncs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: a negedge SPI monitor decodes frames and
// each scenario task compares against hand-computed words and timings.
module tb_spi_cfg_master;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic sclk, copi, ncs, busy, done;

    logic c1_valid = 1'b0, c1_ready;
    logic [6:0] c1_addr = '0;
    logic [7:0] c1_data = '0;
    logic sclk1, copi1, ncs1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_cfg_master #(.CLK_DIV(CLK_DIV), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sclk(sclk), .copi(copi),
        .ncs(ncs), .busy(busy), .done(done));

    spi_cfg_master #(.CLK_DIV(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_addr(c1_addr), .cmd_data(c1_data), .sclk(sclk1), .copi(copi1),
        .ncs(ncs1), .busy(busy1), .done(done1));

    // Monitor for the CLK_DIV=4 instance
    logic [15:0] words[$];
    logic [15:0] mon_sh = '0;
    logic sclk_p = 1'b0, ncs_p = 1'b1, copi_p = 1'b0, busy_p = 1'b0;
    int cyc = 0, mon_bits = 0, mon_ncs_low = 0, mon_done = 0, mon_viol = 0;
    int mon_busy_cyc = 0, last_busy_cyc = 0, last_ncs_low = 0, last_bits = 0;
    int high_run = 0, min_high = 1000, stab = 0, mon_starts = 0;
    int ncs_rise_cyc = 0, busy_fall_cyc = 0;
    bit ended = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_bits = 0; mon_ncs_low = 0; mon_busy_cyc = 0; high_run = 0;
            stab = 0; ended = 1'b0;
            sclk_p = 1'b0; ncs_p = 1'b1; copi_p = 1'b0; busy_p = 1'b0;
        end else begin
            if (done) mon_done++;
            if (busy) mon_busy_cyc++;
            if (busy_p && !busy) begin
                last_busy_cyc = mon_busy_cyc;
                mon_busy_cyc  = 0;
                busy_fall_cyc = cyc;
            end
            stab = (copi !== copi_p) ? 1 : stab + 1;
            if (sclk && !sclk_p) begin
                if (ncs) mon_viol++;
                if (stab < CLK_DIV + 1) mon_viol++;
                mon_sh = {mon_sh[14:0], copi};
                mon_bits++;
            end
            if (sclk_p && sclk && (copi !== copi_p)) mon_viol++;
            if (!ncs) mon_ncs_low++;
            if (ncs) high_run++;
            if (!ncs && ncs_p) begin
                if (ended && high_run < min_high) min_high = high_run;
                high_run = 0;
                mon_starts++;
            end
            if (ncs && !ncs_p) begin
                words.push_back(mon_sh);
                last_bits    = mon_bits;
                last_ncs_low = mon_ncs_low;
                mon_bits     = 0;
                mon_ncs_low  = 0;
                ncs_rise_cyc = cyc;
                ended        = 1'b1;
            end
            sclk_p = sclk; ncs_p = ncs; copi_p = copi; busy_p = busy;
        end
    end

    // Called on a negedge; returns whether the push was accepted at the next posedge.
    task automatic push(input logic [6:0] a, input logic [7:0] d, output bit acc);
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
        acc = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL reset_ncs got %b want 1", ncs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (copi !== 1'b0) begin errors++; $display("FAIL reset_copi got %b want 0", copi); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if (ncs1 !== 1'b1 || c1_ready !== 1'b1) begin errors++; $display("FAIL reset_dut1 got ncs=%b ready=%b want 1 1", ncs1, c1_ready); end
    endtask

    task automatic test_single();
        bit acc;
        int d0;
        words.delete();
        d0 = mon_done;
        push(7'h04, 8'hA5, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", acc); end
        for (int i = 0; i < 400 && words.size() < 1; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++;
        if (words.size() != 1) begin errors++; $display("FAIL single_count got %0d frames want 1", words.size()); end
        else if (words[0] !== 16'h84A5) begin errors++; $display("FAIL single_word got %h want 84a5", words[0]); end
        checks++; if (last_bits != 16) begin errors++; $display("FAIL single_edges got %0d want 16", last_bits); end
        checks++; if (last_ncs_low != 33 * CLK_DIV) begin errors++; $display("FAIL single_ncs_low got %0d want %0d", last_ncs_low, 33 * CLK_DIV); end
        checks++; if (mon_done - d0 != 1) begin errors++; $display("FAIL single_done got %0d pulses want 1", mon_done - d0); end
        checks++; if (last_busy_cyc != 34 * CLK_DIV + 1) begin errors++; $display("FAIL single_busy_len got %0d want %0d", last_busy_cyc, 34 * CLK_DIV + 1); end
        checks++; if (busy_fall_cyc - ncs_rise_cyc != CLK_DIV) begin errors++; $display("FAIL single_busy_tail got %0d want %0d", busy_fall_cyc - ncs_rise_cyc, CLK_DIV); end
        checks++; if (mon_viol != 0) begin errors++; $display("FAIL single_protocol got %0d violations want 0", mon_viol); end
    endtask

    task automatic test_burst();
        bit acc;
        bit exp_acc [6] = '{1, 1, 1, 1, 1, 0};
        logic [15:0] exp_w [5] = '{16'h8111, 16'h8222, 16'h8333, 16'h8444, 16'h8555};
        words.delete();
        min_high = 1000;
        for (int i = 0; i < 6; i++) begin
            push(7'(i + 1), 8'(8'h11 * (i + 1)), acc);
            checks++;
            if (acc !== exp_acc[i]) begin errors++; $display("FAIL burst_accept%0d got %b want %b", i, acc, exp_acc[i]); end
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL burst_ready got %b want 0", cmd_ready); end
        for (int i = 0; i < 2000 && words.size() < 5; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        checks++;
        if (words.size() != 5) begin errors++; $display("FAIL burst_count got %0d want 5", words.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (words[i] !== exp_w[i]) begin errors++; $display("FAIL burst_word%0d got %h want %h", i, words[i], exp_w[i]); end
            end
        end
        checks++; if (min_high < CLK_DIV + 1) begin errors++; $display("FAIL burst_gap got %0d want >= %0d", min_high, CLK_DIV + 1); end
        checks++; if (mon_viol != 0) begin errors++; $display("FAIL burst_protocol got %0d violations want 0", mon_viol); end
    endtask

    task automatic test_backpressure();
        bit acc;
        int n_at_ready;
        logic [15:0] exp_w [5] = '{16'h8A01, 16'h8B02, 16'h8C03, 16'h8D04, 16'h8E05};
        words.delete();
        push(7'h0A, 8'h01, acc);
        for (int i = 0; i < 20 && ncs; i++) @(negedge clk);
        checks++; if (ncs !== 1'b0) begin errors++; $display("FAIL bp_start got ncs=%b want 0", ncs); end
        for (int i = 0; i < 4; i++) begin
            push(7'(8'h0B + i), 8'(i + 2), acc);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL bp_fill%0d got %b want 1", i, acc); end
        end
        cmd_valid = 1'b1; cmd_addr = 7'h7F; cmd_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full%0d got ready=%b want 0", i, cmd_ready); end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
        n_at_ready = words.size();
        checks++; if (cmd_ready !== 1'b1 || n_at_ready != 1) begin errors++; $display("FAIL bp_release got ready=%b frames=%0d want 1 1", cmd_ready, n_at_ready); end
        for (int i = 0; i < 1000 && words.size() < 5; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        checks++;
        if (words.size() != 5) begin errors++; $display("FAIL bp_count got %0d want 5", words.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (words[i] !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, words[i], exp_w[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int d0, s0;
        words.delete();
        push(7'h12, 8'h34, acc);
        push(7'h56, 8'h78, acc);
        for (int i = 0; i < 400 && mon_bits < 9; i++) @(negedge clk);
        checks++; if (mon_bits != 9) begin errors++; $display("FAIL rmid_reach got %0d edges want 9", mon_bits); end
        d0 = mon_done;
        #1 rst = 1'b1;
        #1;
        checks++; if (ncs !== 1'b1 || sclk !== 1'b0) begin errors++; $display("FAIL rmid_async got ncs=%b sclk=%b want 1 0", ncs, sclk); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s0 = mon_starts;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_empty got busy=%b ready=%b want 0 1", busy, cmd_ready); end
        repeat (150) @(negedge clk);
        checks++; if (mon_done != d0) begin errors++; $display("FAIL rmid_done got %0d pulses want 0", mon_done - d0); end
        checks++; if (mon_starts != s0 || words.size() != 0 || ncs !== 1'b1) begin errors++; $display("FAIL rmid_nostart got starts=%0d frames=%0d want 0 0", mon_starts - s0, words.size()); end
    endtask

    task automatic test_clkdiv1();
        int bc = 0, lc = 0, tg = 0, dn = 0;
        logic sp = 1'b0;
        logic [15:0] w = '0;
        bit fin = 1'b0;
        c1_valid = 1'b1; c1_addr = 7'h00; c1_data = 8'hFF;
        @(negedge clk);
        c1_valid = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            if (busy1) bc++; else if (bc > 0) fin = 1'b1;
            if (!ncs1) lc++;
            if (done1) dn++;
            if (sclk1 !== sp) tg++;
            if (sclk1 && !sp) w = {w[14:0], copi1};
            sp = sclk1;
            @(negedge clk);
        end
        checks++; if (w !== 16'h80FF) begin errors++; $display("FAIL div1_word got %h want 80ff", w); end
        checks++; if (bc != 35) begin errors++; $display("FAIL div1_len got %0d want 35", bc); end
        checks++; if (lc != 33) begin errors++; $display("FAIL div1_ncs_low got %0d want 33", lc); end
        checks++; if (tg != 32) begin errors++; $display("FAIL div1_toggles got %0d want 32", tg); end
        checks++; if (dn != 1) begin errors++; $display("FAIL div1_done got %0d want 1", dn); end
    endtask

    task automatic test_loopback();
        bit acc;
        logic [7:0] regs [128];
        logic [7:0] pwm_out;
        for (int i = 0; i < 128; i++) regs[i] = '0;
        words.delete();
        push(7'h04, 8'h80, acc);
        push(7'h00, 8'hFF, acc);
        for (int i = 0; i < 800 && words.size() < 2; i++) @(negedge clk);
        checks++;
        if (words.size() != 2) begin errors++; $display("FAIL loop_count got %0d want 2", words.size()); end
        else begin
            foreach (words[i]) if (words[i][15]) regs[words[i][14:8]] = words[i][7:0];
            pwm_out = regs[0];
            checks++; if (regs[4] !== 8'h80) begin errors++; $display("FAIL loop_duty got %h want 80", regs[4]); end
            checks++; if (pwm_out !== 8'hFF) begin errors++; $display("FAIL loop_enable got %h want ff", pwm_out); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_clkdiv1();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
